// File: rtl/jtopl_dac_ser.sv
// Serialiser from the accumulator's 13-bit signed sample to a YM3014-style
// float word (PAD zeros, 10-bit mantissa LSB first, 3-bit exponent LSB first).
module jtopl_dac_ser #(
  parameter int PAD = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cenop,
  input  logic signed [12:0] snd,
  input  logic               zero,
  output logic               mo,
  output logic               sync,
  output logic               busy,
  output logic [9:0]         mant,
  output logic [2:0]         expo
);

  localparam int N  = PAD + 13;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    mant_q, mant_d;
  logic [2:0]    expo_q, expo_d;
  logic [9:0]    mant_c;
  logic [2:0]    expo_c;
  logic          last;

  // Pick the smallest exponent whose window still holds the sign bit;
  // dropping low bits of a two's complement value is a floor shift.
  always_comb begin
    mant_c = snd[12:3];
    expo_c = 3'd4;
    if (&snd[12:9] || ~|snd[12:9]) begin
      mant_c = snd[9:0];
      expo_c = 3'd1;
    end else if (&snd[12:10] || ~|snd[12:10]) begin
      mant_c = snd[10:1];
      expo_c = 3'd2;
    end else if (snd[12] == snd[11]) begin
      mant_c = snd[11:2];
      expo_c = 3'd3;
    end
  end

  assign last = (state_q == SHIFT) && (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    mant_d  = mant_q;
    expo_d  = expo_q;
    if (cenop) begin
      if (zero) begin
        state_d = SHIFT;
        sr_d    = N'({expo_c, mant_c}) << PAD;
        cnt_d   = '0;
        mant_d  = mant_c;
        expo_d  = expo_c;
      end else if (state_q == SHIFT) begin
        if (last) begin
          state_d = IDLE;
          sr_d    = '0;
          cnt_d   = '0;
        end else begin
          sr_d  = sr_q >> 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      mant_q  <= '0;
      expo_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      mant_q  <= mant_d;
      expo_q  <= expo_d;
    end
  end

  // The shift register is cleared whenever IDLE is entered, so mo idles low.
  assign mo   = sr_q[0];
  assign busy = (state_q == SHIFT);
  assign sync = last;
  assign mant = mant_q;
  assign expo = expo_q;

endmodule

// File: tb/tb_jtopl_dac_ser.sv
// Directed plus randomized bench for jtopl_dac_ser against a word/position model.
module tb_jtopl_dac_ser;

  localparam int PAD = 3;
  localparam int N   = PAD + 13;

  logic               clk = 1'b0;
  logic               rst;
  logic               cenop;
  logic signed [12:0] snd;
  logic               zero;
  logic               mo, sync, busy;
  logic [9:0]         mant;
  logic [2:0]         expo;

  int total = 0;
  int bad   = 0;

  // model: the word being sent and the index of the bit on mo (-1 = idle)
  bit word_m [N];
  int pos_m  = -1;
  int mant_m = 0;
  int expo_m = 0;

  jtopl_dac_ser #(.PAD(PAD)) dut (
    .clk   (clk),
    .rst   (rst),
    .cenop (cenop),
    .snd   (snd),
    .zero  (zero),
    .mo    (mo),
    .sync  (sync),
    .busy  (busy),
    .mant  (mant),
    .expo  (expo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void conv(input int s, output int e, output int m);
    e = 4;
    for (int k = 4; k >= 1; k--)
      if (s >= -(512 << (k - 1)) && s < (512 << (k - 1))) e = k;
    m = (s >>> (e - 1)) & 1023;
  endfunction

  task automatic model_load(input int s);
    int e, m;
    conv(s, e, m);
    for (int i = 0; i < N; i++) begin
      if (i < PAD)           word_m[i] = 1'b0;
      else if (i < PAD + 10) word_m[i] = bit'((m >> (i - PAD)) & 1);
      else                   word_m[i] = bit'((e >> (i - PAD - 10)) & 1);
    end
    mant_m = m;
    expo_m = e;
    pos_m  = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".mo"},   32'(mo),   32'((pos_m >= 0) ? word_m[pos_m] : 1'b0));
    chk({tag, ".sync"}, 32'(sync), 32'(pos_m == N - 1));
    chk({tag, ".busy"}, 32'(busy), 32'(pos_m >= 0));
    chk({tag, ".mant"}, 32'(mant), 32'(mant_m));
    chk({tag, ".expo"}, 32'(expo), 32'(expo_m));
  endtask

  task automatic step(input bit c, input bit z, input int s, input string tag);
    @(negedge clk);
    cenop = c;
    zero  = z;
    snd   = 13'(s);
    @(posedge clk);
    if (c) begin
      if (z) model_load(s);
      else if (pos_m >= 0) begin
        pos_m++;
        if (pos_m == N) pos_m = -1;
      end
    end
    #1;
    check_outs(tag);
  endtask

  // Load one sample, run the rest of the frame with cenop high.
  task automatic frame(input int s, input int len, input string tag);
    step(1'b1, 1'b1, s, tag);
    for (int i = 1; i < len; i++) step(1'b1, 1'b0, s, tag);
  endtask

  int         vals  [6] = '{100, 511, 512, 4095, -4096, -513};
  int         vexp  [6] = '{1, 1, 2, 4, 4, 2};
  int         vmant [6] = '{'h064, 'h1FF, 'h100, 'h1FF, 'h200, 'h2FF};
  logic [17:0] cap;
  int          nsync;
  int          busy_lo;

  initial begin
    rst = 1'b1; cenop = 1'b0; zero = 1'b0; snd = '0;
    #12;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    // snd=0 frame of 18 cenops, checked against a literal bit pattern too
    cap = '0;
    nsync = 0;
    busy_lo = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, (i == 0), 0, "zero_frame");
      cap = {cap[16:0], mo};
      if (sync) nsync++;
      if (busy) busy_lo++;
    end
    chk("zero_frame.bits", 32'(cap), 32'(18'b000_0000000000_100_00));
    chk("zero_frame.nsync", nsync, 1);
    chk("zero_frame.nbusy", busy_lo, 16);

    // conversion corner values, parallel outputs against literals
    foreach (vals[k]) begin
      step(1'b1, 1'b1, vals[k], "conv");
      chk("conv.expo_lit", 32'(expo), 32'(vexp[k]));
      chk("conv.mant_lit", 32'(mant), 32'(vmant[k]));
      for (int i = 1; i < 18; i++) step(1'b1, 1'b0, 0, "conv");
    end

    // short frame: abort after 10 cenops, no sync for the aborted word
    nsync = 0;
    step(1'b1, 1'b1, 1234, "short");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 0, "short");
      if (sync) nsync++;
    end
    chk("short.nsync", nsync, 0);
    step(1'b1, 1'b1, -777, "short_new");
    chk("short_new.pad", 32'(mo), 32'(0));
    frame(-777, 17, "short_tail");

    // back-to-back words every 16 cenops
    nsync = 0;
    busy_lo = 0;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < N; i++) begin
        step(1'b1, (i == 0), 300 * w - 2000, "b2b");
        if (sync) nsync++;
        if (!busy) busy_lo++;
      end
    end
    chk("b2b.nsync", nsync, 4);
    chk("b2b.busy_drop", busy_lo, 0);
    frame(0, 2, "b2b_end");

    // cenop held low mid-word (zero high too) then resume
    step(1'b1, 1'b1, 2047, "hold");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, "hold");
    for (int i = 0; i < 5; i++) step(1'b0, (i == 2), -1, "hold_frozen");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0, "hold_resume");

    // asynchronous reset mid-word, checked before any clock edge
    step(1'b1, 1'b1, -3000, "arst");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 0, "arst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    pos_m = -1; mant_m = 0; expo_m = 0;
    #1;
    check_outs("arst_async");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 0, "arst_after");

    // randomized frames with random cenop gaps
    for (int f = 0; f < 40; f++) begin
      int s, len;
      s   = int'($urandom_range(0, 8191)) - 4096;
      len = int'($urandom_range(8, 20));
      step(1'b1, 1'b1, s, "rand");
      for (int i = 1; i < len; i++) begin
        bit c;
        c = ($urandom_range(0, 3) != 0);
        step(c, (!c && $urandom_range(0, 1) == 1), int'($urandom_range(0, 8191)) - 4096, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
